// File: rtl/dram_controller_pkg.sv
// Shared types and helpers for the FPM DRAM controller.
package dram_controller_pkg;

   localparam int unsigned LANE_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ROW     = 3'd1,
      ST_COL     = 3'd2,
      ST_CAS     = 3'd3,
      ST_PRE     = 3'd4,
      ST_REF_CAS = 3'd5,
      ST_REF_RAS = 3'd6,
      ST_REF_PRE = 3'd7
   } state_t;

   // Byte lanes touched by a transfer; bit 3 is lane 0 (D31:24).
   // The span is left-aligned at lane 0, then shifted to the offset; shifting
   // off the low end caps the transfer at lane 3.
   function automatic logic [LANE_W-1:0] lane_mask(input logic [1:0] siz, input logic [1:0] a);
      logic [LANE_W-1:0] span;
      case (siz)
         2'b01:   span = 4'b1000;
         2'b10:   span = 4'b1100;
         2'b11:   span = 4'b1110;
         default: span = 4'b1111;
      endcase
      return span >> a;
   endfunction

   function automatic int unsigned max3(input int unsigned x, input int unsigned y, input int unsigned z);
      int unsigned m;
      m = (x > y) ? x : y;
      return (m > z) ? m : z;
   endfunction

endpackage

// File: rtl/dram_controller_refresh_timer.sv
// Free-running refresh interval timer with a single-deep pending flag.
module dram_controller_refresh_timer #(
   parameter int unsigned REFRESH_PERIOD = 360
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic ref_pending
);

   localparam int unsigned TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

   logic [TW-1:0] count;
   logic          wrap;

   assign wrap = (count == TW'(REFRESH_PERIOD - 1));

   // Interval counter, 0..REFRESH_PERIOD-1, never paused
   always_ff @(posedge clk) begin
      if (rst)       count <= '0;
      else if (wrap) count <= '0;
      else           count <= count + 1'b1;
   end

   // Pending flag: a new wrap outranks a clear landing on the same edge
   always_ff @(posedge clk) begin
      if (rst)        ref_pending <= 1'b0;
      else if (wrap)  ref_pending <= 1'b1;
      else if (clear) ref_pending <= 1'b0;
   end

endmodule

// File: rtl/dram_controller.sv
// FPM DRAM sequencer for the 68030 bus: CPU accesses plus CAS-before-RAS refresh.
module dram_controller
   import dram_controller_pkg::*;
#(
   parameter int unsigned REFRESH_PERIOD = 360,
   parameter int unsigned RCD_CYCLES     = 1,
   parameter int unsigned RAS_CYCLES     = 2,
   parameter int unsigned RP_CYCLES      = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CS_DRAM_n,
   input  logic        AS_n,
   input  logic        DS_n,
   input  logic        RW,
   input  logic [1:0]  SIZ,
   input  logic [1:0]  A,
   output logic        DRAM_RAS_n,
   output logic [3:0]  DRAM_CAS_n,
   output logic        DRAM_WE_n,
   output logic        DRAM_MUX,
   output logic        DSACK0_DRAM_n,
   output logic        DSACK1_DRAM_n,
   output logic        REFRESH_BUSY
);

   localparam int unsigned MAXP = max3(RCD_CYCLES, RAS_CYCLES, RP_CYCLES);
   localparam int unsigned CW   = $clog2(MAXP + 1);

   state_t        state, next_state;
   logic [CW-1:0] dwell;
   logic          rw_q, abort_q;
   logic [1:0]    siz_q, a_q;
   logic          ref_pending, ref_clear;
   logic          we_eff;

   logic          ras_d, we_d, mux_d, dsack_d, busy_d;
   logic [3:0]    cas_d;
   logic          ras_q, we_q, mux_q, dsack_q, busy_q;
   logic [3:0]    cas_q;

   assign ref_clear = (state == ST_IDLE) && ref_pending;

   dram_controller_refresh_timer #(
      .REFRESH_PERIOD (REFRESH_PERIOD)
   ) u_refresh_timer (
      .clk         (CLK),
      .rst         (RST),
      .clear       (ref_clear),
      .ref_pending (ref_pending)
   );

   // State register and per-state dwell counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         dwell <= '0;
      end else begin
         state <= next_state;
         dwell <= (next_state != state) ? '0 : dwell + 1'b1;
      end
   end

   // Capture the CPU request at ROW entry and remember an early AS negation
   always_ff @(posedge CLK) begin
      if (RST) begin
         rw_q    <= 1'b1;
         siz_q   <= 2'b00;
         a_q     <= 2'b00;
         abort_q <= 1'b0;
      end else begin
         if (state == ST_IDLE && next_state == ST_ROW) begin
            rw_q  <= RW;
            siz_q <= SIZ;
            a_q   <= A;
         end
         if (state == ST_IDLE)
            abort_q <= 1'b0;
         else if ((state == ST_ROW || state == ST_COL) && AS_n)
            abort_q <= 1'b1;
      end
   end

   // Next-state logic; refresh has priority over a CPU request in IDLE
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (ref_pending)              next_state = ST_REF_CAS;
            else if (!CS_DRAM_n && !AS_n) next_state = ST_ROW;
         end
         ST_ROW:     if (dwell == CW'(RCD_CYCLES - 1)) next_state = ST_COL;
         ST_COL:     next_state = (abort_q || AS_n) ? ST_PRE : ST_CAS;
         ST_CAS:     if (AS_n) next_state = ST_PRE;
         ST_PRE:     if (dwell == CW'(RP_CYCLES - 1)) next_state = ST_IDLE;
         ST_REF_CAS: next_state = ST_REF_RAS;
         ST_REF_RAS: if (dwell == CW'(RAS_CYCLES - 1)) next_state = ST_REF_PRE;
         ST_REF_PRE: if (dwell == CW'(RP_CYCLES - 1)) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   assign we_eff = (state == ST_IDLE) ? RW : rw_q;

   // Output decode from the state being entered, so outputs change on the transition edge
   always_comb begin
      ras_d   = 1'b1;
      cas_d   = 4'hF;
      we_d    = 1'b1;
      mux_d   = 1'b0;
      dsack_d = 1'b1;
      busy_d  = 1'b0;
      case (next_state)
         ST_ROW: begin
            ras_d = 1'b0;
            we_d  = we_eff;
         end
         ST_COL: begin
            ras_d = 1'b0;
            we_d  = we_eff;
            mux_d = 1'b1;
         end
         ST_CAS: begin
            ras_d   = 1'b0;
            we_d    = rw_q;
            mux_d   = 1'b1;
            dsack_d = 1'b0;
            if (rw_q)       cas_d = 4'h0;
            else if (!DS_n) cas_d = ~lane_mask(siz_q, a_q);
         end
         ST_REF_CAS: begin
            cas_d  = 4'h0;
            busy_d = 1'b1;
         end
         ST_REF_RAS: begin
            ras_d  = 1'b0;
            cas_d  = 4'h0;
            busy_d = 1'b1;
         end
         ST_REF_PRE: busy_d = 1'b1;
         default: ;
      endcase
   end

   // Output registers; reset forces every strobe inactive on the same edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         ras_q   <= 1'b1;
         cas_q   <= 4'hF;
         we_q    <= 1'b1;
         mux_q   <= 1'b0;
         dsack_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         ras_q   <= ras_d;
         cas_q   <= cas_d;
         we_q    <= we_d;
         mux_q   <= mux_d;
         dsack_q <= dsack_d;
         busy_q  <= busy_d;
      end
   end

   assign DRAM_RAS_n    = ras_q;
   assign DRAM_CAS_n    = cas_q;
   assign DRAM_WE_n     = we_q;
   assign DRAM_MUX      = mux_q;
   assign DSACK0_DRAM_n = dsack_q;
   assign DSACK1_DRAM_n = dsack_q;
   assign REFRESH_BUSY  = busy_q;

endmodule

// File: tb/tb_dram_controller.sv
// Self-checking bench for dram_controller against a cycle-level behavioural model.
module tb_dram_controller;

   localparam int REFRESH_PERIOD = 360;
   localparam int RCD_CYCLES     = 1;
   localparam int RAS_CYCLES     = 2;
   localparam int RP_CYCLES      = 2;
   // Edge at which the refresh request becomes pending -> first DSACK low edge,
   // for a CPU request raised right after that edge.
   localparam int SIM_LAT = 1 + RAS_CYCLES + RP_CYCLES + 1 + (RCD_CYCLES + 2);
   localparam logic [9:0] IDLE_BUS = 10'b1_1111_1_0_11_0;

   logic       CLK = 1'b0;
   logic       RST, CS_DRAM_n, AS_n, DS_n, RW;
   logic [1:0] SIZ, A;
   logic       DRAM_RAS_n, DRAM_WE_n, DRAM_MUX, DSACK0_DRAM_n, DSACK1_DRAM_n, REFRESH_BUSY;
   logic [3:0] DRAM_CAS_n;
   logic [9:0] obs;

   int vectors     = 0;
   int miscompares = 0;
   int edges       = 0;

   dram_controller #(
      .REFRESH_PERIOD (REFRESH_PERIOD),
      .RCD_CYCLES     (RCD_CYCLES),
      .RAS_CYCLES     (RAS_CYCLES),
      .RP_CYCLES      (RP_CYCLES)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .CS_DRAM_n     (CS_DRAM_n),
      .AS_n          (AS_n),
      .DS_n          (DS_n),
      .RW            (RW),
      .SIZ           (SIZ),
      .A             (A),
      .DRAM_RAS_n    (DRAM_RAS_n),
      .DRAM_CAS_n    (DRAM_CAS_n),
      .DRAM_WE_n     (DRAM_WE_n),
      .DRAM_MUX      (DRAM_MUX),
      .DSACK0_DRAM_n (DSACK0_DRAM_n),
      .DSACK1_DRAM_n (DSACK1_DRAM_n),
      .REFRESH_BUSY  (REFRESH_BUSY)
   );

   always #5 CLK = ~CLK;

   // Edges since reset was last sampled; refresh is due every REFRESH_PERIOD of these
   always @(posedge CLK) begin
      if (RST) edges <= 0;
      else     edges <= edges + 1;
   end

   assign obs = {DRAM_RAS_n, DRAM_CAS_n, DRAM_WE_n, DRAM_MUX, DSACK1_DRAM_n, DSACK0_DRAM_n, REFRESH_BUSY};

   function automatic logic [9:0] bus(input logic ras, input logic [3:0] cas, input logic we,
                                      input logic mux, input logic dsack, input logic busy);
      return {ras, cas, we, mux, dsack, dsack, busy};
   endfunction

   // Lanes from offset a upward, size bytes long, clipped at lane 3; lane L drives CAS bit 3-L
   function automatic logic [3:0] model_lanes(input logic [1:0] siz, input logic [1:0] a);
      int n, first;
      logic [3:0] m;
      n     = (siz == 2'b00) ? 4 : int'(siz);
      first = int'(a);
      m     = 4'b0000;
      for (int l = first; l < first + n; l++)
         if (l <= 3) m[3-l] = 1'b1;
      return m;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      CS_DRAM_n = 1'b1; AS_n = 1'b1; DS_n = 1'b1; RW = 1'b1; SIZ = 2'b00; A = 2'b00;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle_inputs();
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (edges < target) tick();
   endtask

   // Keep CPU-only scenarios clear of the refresh window
   task automatic avoid_refresh();
      while ((edges % REFRESH_PERIOD) >= REFRESH_PERIOD - 30 || (edges % REFRESH_PERIOD) < 8) tick();
   endtask

   // One complete CPU cycle: ROW, COL, CAS (with optional DS delay and hold), release, PRE
   task automatic run_txn(input logic rw, input logic [1:0] siz, input logic [1:0] a,
                          input int ds_d, input int hold, input logic read_ds);
      int cas_edges, rel, j;
      logic [3:0] lanes_n, casx;
      logic [9:0] e;
      avoid_refresh();
      lanes_n   = ~model_lanes(siz, a);
      cas_edges = 1 + (rw ? 0 : ds_d) + hold;
      rel       = 2 + cas_edges;
      CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = rw; SIZ = siz; A = a;
      DS_n      = rw ? read_ds : (ds_d == 0 ? 1'b0 : 1'b1);
      for (int s = 0; s < rel + 3; s++) begin
         if (!rw && ds_d > 0 && s == 2 + ds_d) DS_n = 1'b0;
         if (s == rel) begin AS_n = 1'b1; CS_DRAM_n = 1'b1; DS_n = 1'b1; end
         tick();
         if (s == 0)      e = bus(1'b0, 4'hF, rw, 1'b0, 1'b1, 1'b0);
         else if (s == 1) e = bus(1'b0, 4'hF, rw, 1'b1, 1'b1, 1'b0);
         else if (s < rel) begin
            j    = s - 2;
            casx = rw ? 4'h0 : ((ds_d == 0 || j >= ds_d) ? lanes_n : 4'hF);
            e    = bus(1'b0, casx, rw, 1'b1, 1'b0, 1'b0);
         end else e = IDLE_BUS;
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL txn rw=%0d siz=%0d a=%0d ds_d=%0d step=%0d: got %b want %b",
                     rw, siz, a, ds_d, s, obs, e);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obs !== IDLE_BUS) begin
            miscompares++;
            $display("FAIL reset_state k=%0d: got %b want %b", k, obs, IDLE_BUS);
         end
         tick();
      end
   endtask

   task automatic test_read();
      run_txn(1'b1, 2'b00, 2'b00, 0, 0, 1'b0);
      run_txn(1'b1, 2'b01, 2'b11, 0, 2, 1'b1);
   endtask

   task automatic test_byte_write();
      run_txn(1'b0, 2'b01, 2'b10, 2, 0, 1'b1);
   endtask

   task automatic test_word_write();
      run_txn(1'b0, 2'b10, 2'b11, 0, 1, 1'b1);
   endtask

   task automatic test_abort();
      logic [9:0] exp_seq [5];
      avoid_refresh();
      exp_seq[0] = bus(1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_seq[1] = bus(1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_seq[2] = IDLE_BUS;
      exp_seq[3] = IDLE_BUS;
      exp_seq[4] = IDLE_BUS;
      CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = 1'b0; SIZ = 2'b00; A = 2'b00; DS_n = 1'b0;
      for (int s = 0; s < 5; s++) begin
         if (s == 1) begin AS_n = 1'b1; CS_DRAM_n = 1'b1; DS_n = 1'b1; end
         tick();
         vectors++;
         if (obs !== exp_seq[s]) begin
            miscompares++;
            $display("FAIL abort step=%0d: got %b want %b", s, obs, exp_seq[s]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] e;
      avoid_refresh();
      CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = 1'b1; SIZ = 2'b00; A = 2'b00; DS_n = 1'b0;
      tick(); tick(); tick();
      AS_n = 1'b1;
      tick();
      AS_n = 1'b0;
      // Release edge E is step 0; PRE holds RP_CYCLES, IDLE one edge, then ROW/COL/CAS
      for (int s = 0; s < 6; s++) begin
         if (s > 0) tick();
         if (s < RP_CYCLES + 1)      e = IDLE_BUS;
         else if (s == RP_CYCLES + 1) e = bus(1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
         else if (s == RP_CYCLES + 2) e = bus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
         else                         e = bus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL back_to_back step=%0d: got %b want %b", s, obs, e);
         end
      end
      idle_inputs();
      tick(); tick(); tick();
   endtask

   task automatic test_random();
      logic rw;
      logic [1:0] siz, a;
      for (int n = 0; n < 40; n++) begin
         rw  = 1'($urandom_range(0, 1));
         siz = 2'($urandom_range(0, 3));
         a   = 2'($urandom_range(0, 3));
         run_txn(rw, siz, a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_refresh();
      int rise1, n;
      logic [9:0] e;
      do_reset();
      wait_until(REFRESH_PERIOD - 1);
      for (int t = REFRESH_PERIOD - 1; t <= REFRESH_PERIOD + 6; t++) begin
         if (t > REFRESH_PERIOD - 1) tick();
         if (t == REFRESH_PERIOD + 2 || t == REFRESH_PERIOD + 3) begin
            vectors++;
            if ({DRAM_RAS_n, REFRESH_BUSY} !== 2'b01) begin
               miscompares++;
               $display("FAIL refresh_ras edge=%0d: got ras=%b busy=%b want ras=0 busy=1",
                        t, DRAM_RAS_n, REFRESH_BUSY);
            end
         end else begin
            if (t == REFRESH_PERIOD + 1)      e = bus(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
            else if (t == REFRESH_PERIOD + 4 || t == REFRESH_PERIOD + 5)
                                              e = bus(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
            else                              e = IDLE_BUS;
            vectors++;
            if (obs !== e) begin
               miscompares++;
               $display("FAIL refresh edge=%0d: got %b want %b", t, obs, e);
            end
         end
      end
      rise1 = REFRESH_PERIOD + 1;
      n = 0;
      while (REFRESH_BUSY !== 1'b1 && n < REFRESH_PERIOD + 40) begin
         tick();
         n++;
      end
      vectors++;
      if (REFRESH_BUSY !== 1'b1 || edges - rise1 != REFRESH_PERIOD) begin
         miscompares++;
         $display("FAIL refresh_period: got %0d busy=%b want %0d", edges - rise1, REFRESH_BUSY, REFRESH_PERIOD);
      end
      wait_until(2 * REFRESH_PERIOD + 8);
   endtask

   task automatic test_simultaneous();
      int lat;
      bit seen;
      do_reset();
      wait_until(REFRESH_PERIOD);
      CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = 1'b1; SIZ = 2'b00; A = 2'b00; DS_n = 1'b0;
      lat  = -1;
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         tick();
         if (k == 1) begin
            vectors++;
            if (REFRESH_BUSY !== 1'b1 || DSACK0_DRAM_n !== 1'b1) begin
               miscompares++;
               $display("FAIL simultaneous_first: got busy=%b dsack0=%b want busy=1 dsack0=1",
                        REFRESH_BUSY, DSACK0_DRAM_n);
            end
         end
         if (DSACK0_DRAM_n === 1'b0) begin
            seen = 1'b1;
            lat  = edges - REFRESH_PERIOD;
         end
      end
      vectors++;
      if (!seen || lat != SIM_LAT || DSACK1_DRAM_n !== 1'b0) begin
         miscompares++;
         $display("FAIL simultaneous_latency: got %0d want %0d", lat, SIM_LAT);
      end
      idle_inputs();
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid_cas();
      avoid_refresh();
      CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = 1'b1; SIZ = 2'b00; A = 2'b00; DS_n = 1'b0;
      tick(); tick(); tick();
      vectors++;
      if (obs !== bus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL mid_cas_pre: got %b want %b", obs, bus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
      RST = 1'b1;
      tick();
      vectors++;
      if (obs !== IDLE_BUS) begin
         miscompares++;
         $display("FAIL mid_cas_reset: got %b want %b", obs, IDLE_BUS);
      end
      RST = 1'b0;
      idle_inputs();
      // A cleared interval counter means the next refresh starts exactly one period later
      wait_until(REFRESH_PERIOD);
      vectors++;
      if (REFRESH_BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_cas_timer_early: got busy=%b want 0", REFRESH_BUSY);
      end
      tick();
      vectors++;
      if (REFRESH_BUSY !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_cas_timer_due: got busy=%b want 1", REFRESH_BUSY);
      end
      run_txn(1'b1, 2'b00, 2'b00, 0, 0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b1;
      idle_inputs();
      test_reset();
      test_read();
      test_byte_write();
      test_word_write();
      test_abort();
      test_back_to_back();
      test_random();
      test_refresh();
      test_simultaneous();
      test_reset_mid_cas();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
